pic: RTL and testbench

- 8-line programmable interrupt controller, 8259-lite.
- Collects interrupt requests from peripherals (timer, PS/2 keyboard, …) and arbitrates them by fixed priority.
- Presents the winner to the core on the irq / irq_in vector pair.
- Exposes IRR/ISR/IMR through core I/O ports; non-specific and specific EOI supported; no ICW init sequence.

---
 rtl/pic_if.sv | 22 ++
 rtl/pic.sv | 151 +++++++++++++++
 tb/tb_pic.sv | 276 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/pic_if.sv
// Core-side bus of the pic: interrupt presentation (irq/irq_in/ack) and the
// byte-wide I/O port used to reach IRR/ISR/IMR.
interface pic_if;
  logic        irq;
  logic [7:0]  irq_in;
  logic        ack;
  logic [15:0] port_a;
  logic        port_w;
  logic        port_r;
  logic [7:0]  port_i;
  logic [7:0]  port_o;

  modport master (
    input  irq, irq_in, port_o,
    output ack, port_a, port_w, port_r, port_i
  );

  modport slave (
    output irq, irq_in, port_o,
    input  ack, port_a, port_w, port_r, port_i
  );
endinterface

// File: rtl/pic.sv
// 8-line fixed-priority interrupt controller (8259-lite) with IRR/ISR/IMR on two I/O ports.
// Optional macro PIC_AUTO_EOI_EN: acknowledge does not set ISR (auto-EOI).
module pic #(
  parameter logic [15:0] PORT_BASE   = 16'h0020,
  parameter logic [7:0]  VECTOR_BASE = 8'h08
) (
  input  logic       clock,
  input  logic       reset,
  input  logic [7:0] lines,
  pic_if.slave       bus
);

  typedef enum logic {IDLE, REQ} state_e;

`ifdef PIC_AUTO_EOI_EN
  localparam bit AUTO_EOI = 1'b1;
`else
  localparam bit AUTO_EOI = 1'b0;
`endif

  localparam logic [15:0] MASK_PORT  = PORT_BASE + 16'd1;
  localparam logic [7:0]  CMD_NS_EOI = 8'h20;
  localparam logic [4:0]  CMD_SP_EOI = 5'b01100;
  localparam logic [7:0]  CMD_RD_IRR = 8'h0A;
  localparam logic [7:0]  CMD_RD_ISR = 8'h0B;

  state_e     state_q;
  logic [7:0] lines_q;
  logic [7:0] irr_q, irr_d;
  logic [7:0] isr_q, isr_d;
  logic [7:0] imr_q, imr_d;
  logic       rdsel_q, rdsel_d;
  logic [2:0] sel_q;
  logic       irq_q;
  logic [7:0] irq_in_q;

  logic [7:0] rise;
  logic [7:0] cand;
  logic [7:0] elig;
  logic [7:0] eoi_clr;
  logic [2:0] win_idx;
  logic       wr_cmd;
  logic       wr_mask;
  logic       take;
  logic       unused_port_r;

  assign unused_port_r = bus.port_r;

  assign wr_cmd  = bus.port_w && (bus.port_a == PORT_BASE);
  assign wr_mask = bus.port_w && (bus.port_a == MASK_PORT);
  assign take    = (state_q == REQ) && bus.ack;
  assign rise    = lines & ~lines_q;
  assign cand    = irr_q & ~imr_q;

  // A requested, unmasked line is shadowed by any in-service line of equal or higher priority.
  always_comb begin
    logic blocked;
    // NOTE: every combinational output gets a default first so no path leaves it unassigned (no latch).
    blocked = 1'b0;
    elig    = '0;
    for (int n = 0; n < 8; n++) begin
      blocked = blocked | isr_q[n];
      elig[n] = cand[n] & ~blocked;
    end
  end

  always_comb begin
    win_idx = '0;
    for (int n = 7; n >= 0; n--) begin
      if (elig[n]) win_idx = n[2:0];
    end
  end

  // isr & ~(isr - 1) isolates the lowest set bit, and is zero when ISR is empty.
  always_comb begin
    eoi_clr = '0;
    if (wr_cmd) begin
      if (bus.port_i == CMD_NS_EOI)             eoi_clr = isr_q & ~(isr_q - 8'd1);
      else if (bus.port_i[7:3] == CMD_SP_EOI)   eoi_clr = 8'd1 << bus.port_i[2:0];
    end
  end

  // EOI works on the pre-acknowledge ISR; a fresh edge on the acknowledged line re-arms IRR.
  always_comb begin
    isr_d   = isr_q & ~eoi_clr;
    irr_d   = irr_q;
    if (take) begin
      irr_d[sel_q] = 1'b0;
      if (!AUTO_EOI) isr_d[sel_q] = 1'b1;
    end
    irr_d   = irr_d | rise;
    imr_d   = wr_mask ? bus.port_i : imr_q;
    rdsel_d = rdsel_q;
    if (wr_cmd && (bus.port_i == CMD_RD_IRR))      rdsel_d = 1'b0;
    else if (wr_cmd && (bus.port_i == CMD_RD_ISR)) rdsel_d = 1'b1;
  end

  always_ff @(posedge clock) begin
    // NOTE: state registers use non-blocking assignment so every flop samples pre-edge values.
    if (reset) begin
      lines_q <= '0;
      irr_q   <= '0;
      isr_q   <= '0;
      imr_q   <= 8'hFF;
      rdsel_q <= 1'b0;
    end else begin
      lines_q <= lines;
      irr_q   <= irr_d;
      isr_q   <= isr_d;
      imr_q   <= imr_d;
      rdsel_q <= rdsel_d;
    end
  end

  // Presentation FSM: the winner is frozen while in REQ; leaving REQ always costs one IDLE cycle.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q  <= IDLE;
      sel_q    <= '0;
      irq_q    <= 1'b0;
      irq_in_q <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (|elig) begin
            sel_q    <= win_idx;
            irq_in_q <= VECTOR_BASE + {5'd0, win_idx};
            irq_q    <= 1'b1;
            state_q  <= REQ;
          end
        end
        REQ: begin
          if (bus.ack || !cand[sel_q]) begin
            irq_q   <= 1'b0;
            state_q <= IDLE;
          end
        end
      endcase
    end
  end

  always_comb begin
    bus.port_o = 8'h00;
    if (bus.port_a == PORT_BASE)      bus.port_o = rdsel_q ? isr_q : irr_q;
    else if (bus.port_a == MASK_PORT) bus.port_o = imr_q;
  end

  assign bus.irq    = irq_q;
  assign bus.irq_in = irq_in_q;

endmodule

// File: tb/tb_pic.sv
// Self-checking bench for pic: directed vector table, hand-written corner
// sequences, then random traffic against a behavioural model.
module tb_pic;

`ifdef PIC_AUTO_EOI_EN
  localparam bit AUTO = 1'b1;
`else
  localparam bit AUTO = 1'b0;
`endif
  localparam logic [7:0]  VB   = 8'h08;
  localparam logic [15:0] CMDP = 16'h0020;
  localparam logic [15:0] MSKP = 16'h0021;

  logic       clock = 1'b0;
  logic       reset;
  logic [7:0] lines;

  pic_if bus();

  pic dut (
    .clock (clock),
    .reset (reset),
    .lines (lines),
    .bus   (bus)
  );

  always #5 clock = ~clock;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  // ---------------- behavioural reference model ----------------
  bit [7:0] m_irr, m_isr, m_imr, m_lines;
  bit       m_rdsel, m_irq;
  int       m_sel;
  bit [7:0] m_vec;

  function automatic void model_step();
    bit [7:0] cand, isr_n, irr_n;
    bit       took;
    int       picked;
    if (reset) begin
      m_irr = 0; m_isr = 0; m_imr = 8'hFF; m_lines = 0;
      m_rdsel = 0; m_irq = 0; m_sel = 0; m_vec = 0;
      return;
    end
    cand  = m_irr & ~m_imr;
    took  = m_irq && bus.ack;
    isr_n = m_isr;
    if (bus.port_w && bus.port_a == CMDP) begin
      if (bus.port_i == 8'h20) begin
        for (int k = 0; k < 8; k++)
          if (m_isr[k]) begin isr_n[k] = 1'b0; break; end
      end else if (bus.port_i >= 8'h60 && bus.port_i <= 8'h67) begin
        isr_n[int'(bus.port_i) - 'h60] = 1'b0;
      end else if (bus.port_i == 8'h0A) begin
        m_rdsel = 1'b0;
      end else if (bus.port_i == 8'h0B) begin
        m_rdsel = 1'b1;
      end
    end
    if (took && !AUTO) isr_n[m_sel] = 1'b1;
    irr_n = m_irr;
    if (took) irr_n[m_sel] = 1'b0;
    irr_n = irr_n | (lines & ~m_lines);
    if (m_irq) begin
      if (took || !cand[m_sel]) m_irq = 1'b0;
    end else begin
      picked = -1;
      // Line n may be presented when no ISR bit in 0..n is set, i.e. ISR is a multiple of 2^(n+1).
      for (int n = 0; n < 8; n++)
        if (picked < 0 && cand[n] && (int'(m_isr) % (1 << (n + 1))) == 0) picked = n;
      if (picked >= 0) begin
        m_irq = 1'b1;
        m_sel = picked;
        m_vec = 8'((int'(VB) + picked) % 256);
      end
    end
    if (bus.port_w && bus.port_a == MSKP) m_imr = bus.port_i;
    m_irr   = irr_n;
    m_isr   = isr_n;
    m_lines = lines;
  endfunction

  function automatic bit [7:0] model_read(input logic [15:0] a);
    if (a == CMDP) return m_rdsel ? m_isr : m_irr;
    if (a == MSKP) return m_imr;
    return 8'h00;
  endfunction

  // ---------------- stimulus helpers ----------------
  task automatic drive(input logic r, input logic [7:0] l, input logic a, input logic w,
                       input logic [15:0] addr, input logic [7:0] d);
    reset      = r;
    lines      = l;
    bus.ack    = a;
    bus.port_w = w;
    bus.port_a = addr;
    bus.port_i = d;
    bus.port_r = !w;
  endtask

  task automatic clk_step();
    @(posedge clock);
    model_step();
    @(negedge clock);
  endtask

  task automatic step(input logic [7:0] l, input logic a, input logic w,
                      input logic [15:0] addr, input logic [7:0] d);
    drive(1'b0, l, a, w, addr, d);
    clk_step();
  endtask

  typedef struct {
    logic [7:0]  lines;
    logic        ack;
    logic        wr;
    logic [15:0] addr;
    logic [7:0]  data;
    logic [7:0]  exp_rd;
    logic        exp_irq;
    logic [7:0]  exp_vec;
  } vec_t;

  vec_t tbl[$];

  function automatic vec_t mk(input logic [7:0] l, input logic a, input logic w,
                              input logic [15:0] addr, input logic [7:0] d,
                              input logic [7:0] rd, input logic irq, input logic [7:0] vec);
    vec_t v;
    v.lines = l; v.ack = a; v.wr = w; v.addr = addr; v.data = d;
    v.exp_rd = rd; v.exp_irq = irq; v.exp_vec = vec;
    return v;
  endfunction

  initial begin
    logic [7:0] rl;
    logic       ra, rw, rr;
    logic [15:0] radr;
    logic [7:0] rd;

    // exp_rd is the read before this cycle's edge; exp_irq/exp_vec are after it.
    tbl.push_back(mk(8'h00, 0, 1, MSKP, 8'hFE, 8'hFF, 0, 8'h00));
    tbl.push_back(mk(8'h01, 0, 0, CMDP, 8'h00, 8'h00, 0, 8'h00));
    tbl.push_back(mk(8'h00, 0, 0, CMDP, 8'h00, 8'h01, 1, 8'h08));
    tbl.push_back(mk(8'h00, 1, 0, CMDP, 8'h00, 8'h01, 0, 8'h08));
    tbl.push_back(mk(8'h00, 0, 1, CMDP, 8'h0B, 8'h00, 0, 8'h08));
    tbl.push_back(mk(8'h00, 0, 0, CMDP, 8'h00, AUTO ? 8'h00 : 8'h01, 0, 8'h08));
    tbl.push_back(mk(8'h00, 0, 1, CMDP, 8'h20, AUTO ? 8'h00 : 8'h01, 0, 8'h08));
    tbl.push_back(mk(8'h00, 0, 1, MSKP, 8'h00, 8'hFE, 0, 8'h08));
    tbl.push_back(mk(8'h0A, 0, 0, CMDP, 8'h00, 8'h00, 0, 8'h08));
    tbl.push_back(mk(8'h00, 0, 0, CMDP, 8'h00, 8'h00, 1, 8'h09));
    tbl.push_back(mk(8'h00, 1, 0, CMDP, 8'h00, 8'h00, 0, 8'h09));
    tbl.push_back(mk(8'h00, 0, 0, CMDP, 8'h00, AUTO ? 8'h00 : 8'h02, AUTO, AUTO ? 8'h0B : 8'h09));
    tbl.push_back(mk(8'h00, 0, 1, CMDP, 8'h20, AUTO ? 8'h00 : 8'h02, AUTO, AUTO ? 8'h0B : 8'h09));
    tbl.push_back(mk(8'h00, 0, 0, CMDP, 8'h00, 8'h00, 1, 8'h0B));
    tbl.push_back(mk(8'h00, 1, 0, CMDP, 8'h00, 8'h00, 0, 8'h0B));
    tbl.push_back(mk(8'h00, 0, 1, CMDP, 8'h63, AUTO ? 8'h00 : 8'h08, 0, 8'h0B));
    tbl.push_back(mk(8'h00, 0, 1, CMDP, 8'h0A, 8'h00, 0, 8'h0B));
    tbl.push_back(mk(8'h00, 0, 0, MSKP, 8'h00, 8'h00, 0, 8'h0B));
    tbl.push_back(mk(8'h00, 0, 0, CMDP, 8'h00, 8'h00, 0, 8'h0B));

    // Reset state
    drive(1'b1, 8'h00, 1'b0, 1'b0, CMDP, 8'h00);
    @(negedge clock);
    clk_step();
    clk_step();
    drive(1'b0, 8'h00, 1'b0, 1'b0, CMDP, 8'h00);
    #1;
    check("reset irq", bus.irq, 1'b0);
    check("reset irq_in", bus.irq_in, 8'h00);
    check("reset IRR", bus.port_o, 8'h00);
    bus.port_a = MSKP; #1;
    check("reset IMR", bus.port_o, 8'hFF);
    bus.port_a = 16'h0022; #1;
    check("unmapped read", bus.port_o, 8'h00);

    foreach (tbl[i]) begin
      drive(1'b0, tbl[i].lines, tbl[i].ack, tbl[i].wr, tbl[i].addr, tbl[i].data);
      #1;
      check($sformatf("vec%0d port_o", i), bus.port_o, tbl[i].exp_rd);
      clk_step();
      check($sformatf("vec%0d irq", i), bus.irq, tbl[i].exp_irq);
      check($sformatf("vec%0d irq_in", i), bus.irq_in, tbl[i].exp_vec);
    end

    // Mask drops the line while it is being presented, then unmask re-presents it.
    step(8'h10, 0, 0, CMDP, 8'h00); check("mask irr set", bus.irq, 1'b0);
    step(8'h00, 0, 0, CMDP, 8'h00); check("mask pres irq", bus.irq, 1'b1);
    check("mask pres vec", bus.irq_in, 8'h0C);
    step(8'h00, 0, 1, MSKP, 8'h10); check("mask wr cycle irq", bus.irq, 1'b1);
    step(8'h00, 0, 0, CMDP, 8'h00); check("mask dropped irq", bus.irq, 1'b0);
    check("mask IRR kept", bus.port_o, 8'h10);
    step(8'h00, 0, 1, MSKP, 8'h00); check("unmask wr irq", bus.irq, 1'b0);
    step(8'h00, 0, 0, CMDP, 8'h00); check("re-present irq", bus.irq, 1'b1);
    check("re-present vec", bus.irq_in, 8'h0C);
    step(8'h00, 1, 0, CMDP, 8'h00); check("line4 ack irq", bus.irq, 1'b0);

    // Line 0 preempts in-service line 4; line 5 waits for the EOIs.
    step(8'h21, 0, 0, CMDP, 8'h00); check("nest edge irq", bus.irq, 1'b0);
    step(8'h00, 0, 0, CMDP, 8'h00); check("nest l0 irq", bus.irq, 1'b1);
    check("nest l0 vec", bus.irq_in, 8'h08);
    step(8'h00, 1, 0, CMDP, 8'h00); check("nest l0 ack", bus.irq, 1'b0);
    step(8'h00, 0, 0, CMDP, 8'h00); check("nest l5 blocked a", bus.irq, AUTO);
    check("nest vec a", bus.irq_in, AUTO ? 8'h0D : 8'h08);
    step(8'h00, 0, 1, CMDP, 8'h20); check("nest l5 blocked b", bus.irq, AUTO);
    step(8'h00, 0, 0, CMDP, 8'h00); check("nest l5 blocked c", bus.irq, AUTO);
    step(8'h00, 0, 1, CMDP, 8'h64); check("nest l5 blocked d", bus.irq, AUTO);
    step(8'h00, 0, 0, CMDP, 8'h00); check("nest l5 irq", bus.irq, 1'b1);
    check("nest l5 vec", bus.irq_in, 8'h0D);
    step(8'h00, 1, 0, CMDP, 8'h00); check("nest l5 ack", bus.irq, 1'b0);
    step(8'h00, 0, 1, CMDP, 8'h20);

    // Reset while presenting, with an in-service line.
    step(8'h04, 0, 0, CMDP, 8'h00);
    step(8'h00, 0, 0, CMDP, 8'h00); check("rst pre l2 vec", bus.irq_in, 8'h0A);
    step(8'h00, 1, 0, CMDP, 8'h00);
    step(8'h01, 0, 0, CMDP, 8'h00);
    step(8'h01, 0, 0, CMDP, 8'h00); check("rst pre REQ irq", bus.irq, 1'b1);
    check("rst pre REQ vec", bus.irq_in, 8'h08);
    drive(1'b1, 8'h00, 1'b0, 1'b0, CMDP, 8'h00);
    clk_step();
    check("midrst irq", bus.irq, 1'b0);
    check("midrst irq_in", bus.irq_in, 8'h00);
    check("midrst IRR", bus.port_o, 8'h00);
    bus.port_a = MSKP; #1;
    check("midrst IMR", bus.port_o, 8'hFF);
    step(8'h00, 0, 1, CMDP, 8'h0B);
    check("midrst ISR", bus.port_o, 8'h00);
    check("midrst idle irq", bus.irq, 1'b0);

    // Random traffic against the model.
    drive(1'b1, 8'h00, 1'b0, 1'b0, CMDP, 8'h00);
    clk_step();
    clk_step();
    rl = 8'h00;
    for (int i = 0; i < 3000; i++) begin
      check("rand irq", bus.irq, m_irq);
      check("rand irq_in", bus.irq_in, m_vec);
      rr = ($urandom_range(0, 299) == 0);
      rl = rr ? 8'h00 : rl ^ (8'($urandom) & 8'($urandom) & 8'($urandom));
      ra = ($urandom_range(0, 2) == 0);
      rw = ($urandom_range(0, 5) == 0);
      case ($urandom_range(0, 3))
        0, 1:    radr = CMDP;
        2:       radr = MSKP;
        default: radr = 16'($urandom_range(0, 3) * 16'h0011);
      endcase
      case ($urandom_range(0, 4))
        0:       rd = 8'h20;
        1:       rd = 8'h60 | 8'($urandom_range(0, 7));
        2:       rd = 8'h0A;
        3:       rd = 8'h0B;
        default: rd = 8'($urandom);
      endcase
      if (radr == MSKP) rd = 8'($urandom) & 8'($urandom);
      drive(rr, rl, ra, rw, radr, rd);
      #1;
      check("rand port_o", bus.port_o, model_read(radr));
      clk_step();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
